// File: rtl/riscv_serial_div_pkg.sv
// Shared encodings for the serial divider: op codes and FSM state type.
package riscv_serial_div_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

endpackage

// File: rtl/riscv_serial_div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module riscv_serial_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  // rem < divisor on entry, so shifted < 2*divisor and the result fits WIDTH bits
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, divisor_i};
    borrow  = diff[WIDTH];
    rem_o   = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/riscv_serial_div.sv
// Iterative RISC-V DIV/DIVU/REM/REMU unit, one restoring step per cycle.
// Optional DIV_TAG_PROP_EN adds a 1-bit tag carried from issue to result.
//
// state    | meaning
// DIV_IDLE | ready_o=1, waiting for enable_i
// DIV_BUSY | iterating on magnitudes, counter counts down to 0
// DIV_DONE | valid_o=1, result held until ex_ready_i
module riscv_serial_div
  import riscv_serial_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             kill_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             ex_ready_i,
`ifdef DIV_TAG_PROP_EN
  input  logic             tag_a_i,
  input  logic             tag_b_i,
  output logic             tag_o,
`endif
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r, quo_r, div_mag_r;
  logic             is_rem_r, neg_q_r, neg_r_r;

  logic [WIDTH-1:0] step_rem, step_quo, q_fix, r_fix, a_mag, b_mag;
  logic             a_neg, b_neg, is_rem;

  riscv_serial_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_r),
    .quo_i     (quo_r),
    .divisor_i (div_mag_r),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    a_neg  = op_is_signed(op_i) & op_a_i[WIDTH-1];
    b_neg  = op_is_signed(op_i) & op_b_i[WIDTH-1];
    a_mag  = a_neg ? -op_a_i : op_a_i;
    b_mag  = b_neg ? -op_b_i : op_b_i;
    is_rem = (op_i == DIV_OP_REM) || (op_i == DIV_OP_REMU);
    q_fix  = neg_q_r ? -step_quo : step_quo;
    r_fix  = neg_r_r ? -step_rem : step_rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DIV_IDLE;
      cnt       <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      div_mag_r <= '0;
      is_rem_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      ready_o   <= 1'b1;
      valid_o   <= 1'b0;
      result_o  <= '0;
`ifdef DIV_TAG_PROP_EN
      tag_o     <= 1'b0;
`endif
    end else if (kill_i) begin
      // flush wins in every state, including over a same-cycle issue
      state    <= DIV_IDLE;
      cnt      <= '0;
      ready_o  <= 1'b1;
      valid_o  <= 1'b0;
      result_o <= '0;
`ifdef DIV_TAG_PROP_EN
      tag_o    <= 1'b0;
`endif
    end else begin
      case (state)
        DIV_IDLE: begin
          if (enable_i && ready_o) begin
            ready_o <= 1'b0;
`ifdef DIV_TAG_PROP_EN
            tag_o   <= tag_a_i | tag_b_i;
`endif
            if (op_b_i == '0) begin
              // RISC-V divide-by-zero: quotient all ones, remainder is the raw dividend
              result_o <= is_rem ? op_a_i : '1;
              valid_o  <= 1'b1;
              state    <= DIV_DONE;
            end else begin
              rem_r     <= '0;
              quo_r     <= a_mag;
              div_mag_r <= b_mag;
              is_rem_r  <= is_rem;
              neg_q_r   <= a_neg ^ b_neg;
              neg_r_r   <= a_neg;
              cnt       <= CNT_W'(WIDTH - 1);
              state     <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          rem_r <= step_rem;
          quo_r <= step_quo;
          if (cnt == '0) begin
            result_o <= is_rem_r ? r_fix : q_fix;
            valid_o  <= 1'b1;
            state    <= DIV_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV_DONE: begin
          if (ex_ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state   <= DIV_IDLE;
          end
        end
        default: begin
          state   <= DIV_IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_serial_div.sv
// Directed bench for riscv_serial_div: scoreboarded results, latency,
// backpressure, kill, async reset, and the optional tag path.
module tb_riscv_serial_div;
  import riscv_serial_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        ex_ready_i = 1'b0;
  logic        ready_o, valid_o;
  logic [31:0] result_o;
`ifdef DIV_TAG_PROP_EN
  logic        tag_a_i = 1'b0;
  logic        tag_b_i = 1'b0;
  logic        tag_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  riscv_serial_div #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (enable_i),
    .kill_i     (kill_i),
    .op_i       (op_i),
    .op_a_i     (op_a_i),
    .op_b_i     (op_b_i),
    .ex_ready_i (ex_ready_i),
`ifdef DIV_TAG_PROP_EN
    .tag_a_i    (tag_a_i),
    .tag_b_i    (tag_b_i),
    .tag_o      (tag_o),
`endif
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drive one issue cycle at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic push, input logic [31:0] exp);
    int n = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", {31'b0, ready_o}, 32'd1);
    enable_i = 1'b1;
    op_i     = op;
    op_a_i   = a;
    op_b_i   = b;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    enable_i = 1'b0;
    op_a_i   = $urandom;
    op_b_i   = $urandom;
  endtask

  // wait for valid_o, check latency and scoreboard, optionally hand the result off
  task automatic collect(input string tag, input int exp_lat, input logic take);
    int lat = 1;
    logic rdy_seen = 1'b0;
    logic [31:0] exp;
    while (!valid_o && lat < 60) begin
      rdy_seen |= ready_o;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, {31'b0, valid_o}, 32'd1);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy_ready"}, {31'b0, rdy_seen | ready_o}, 32'd0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    chk({tag, "_result"}, result_o, exp);
    if (take) begin
      ex_ready_i = 1'b1;
      @(negedge clk);
      ex_ready_i = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] held;
    int stable;
    int vseen;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);

    issue(DIV_OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14);
    collect("divu_100_7", 33, 1'b1);
    issue(DIV_OP_REMU, 32'd100, 32'd7, 1'b1, 32'd2);
    collect("remu_100_7", 33, 1'b1);
    issue(DIV_OP_DIV, -32'sd20, 32'd3, 1'b1, 32'hFFFFFFFA);
    collect("div_m20_3", 33, 1'b1);
    issue(DIV_OP_REM, -32'sd20, 32'd3, 1'b1, 32'hFFFFFFFE);
    collect("rem_m20_3", 33, 1'b1);
    issue(DIV_OP_REM, 32'd20, -32'sd3, 1'b1, 32'd2);
    collect("rem_20_m3", 33, 1'b1);
    issue(DIV_OP_DIVU, 32'd5, 32'd0, 1'b1, 32'hFFFFFFFF);
    collect("divu_by0", 1, 1'b1);
    issue(DIV_OP_REM, 32'd5, 32'd0, 1'b1, 32'd5);
    collect("rem_by0", 1, 1'b1);
    issue(DIV_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000);
    collect("div_ovf", 33, 1'b1);
    issue(DIV_OP_REM, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0);
    collect("rem_ovf", 33, 1'b1);

    // backpressure: result held, competing issue ignored
    issue(DIV_OP_DIVU, 32'd1000, 32'd9, 1'b1, 32'd111);
    collect("bp", 33, 1'b0);
    held = result_o;
    stable = 0;
    enable_i = 1'b1; op_i = DIV_OP_DIVU; op_a_i = 32'd9; op_b_i = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid_o && !ready_o && result_o === held) stable++;
    end
    chk("bp_stable", stable, 10);
    chk("bp_result_held", result_o, 32'd111);
    enable_i = 1'b0;
    ex_ready_i = 1'b1;
    @(negedge clk);
    ex_ready_i = 1'b0;
    chk("bp_idle_ready", {31'b0, ready_o}, 32'd1);
    chk("bp_idle_valid", {31'b0, valid_o}, 32'd0);

    // kill in IDLE beats a same-cycle issue
    enable_i = 1'b1; kill_i = 1'b1; op_i = DIV_OP_DIVU; op_a_i = 32'd8; op_b_i = 32'd0;
    @(negedge clk);
    enable_i = 1'b0; kill_i = 1'b0;
    chk("kill_idle_ready", {31'b0, ready_o}, 32'd1);
    chk("kill_idle_valid", {31'b0, valid_o}, 32'd0);

    // kill at iteration 15
    issue(DIV_OP_DIVU, 32'd1000, 32'd3, 1'b0, 32'd0);
    repeat (14) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("kill_busy_ready", {31'b0, ready_o}, 32'd1);
    vseen = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) vseen++;
      @(negedge clk);
    end
    chk("kill_no_valid", vseen, 0);

    // async reset at iteration 20
    issue(DIV_OP_DIV, 32'd77777, 32'd13, 1'b0, 32'd0);
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", {31'b0, ready_o}, 32'd1);
    chk("arst_valid", {31'b0, valid_o}, 32'd0);
    chk("arst_result", result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(DIV_OP_DIVU, 32'hFFFFFFFF, 32'd16, 1'b1, 32'h0FFFFFFF);
    collect("post_rst", 33, 1'b1);

`ifdef DIV_TAG_PROP_EN
    tag_a_i = 1'b1; tag_b_i = 1'b0;
    issue(DIV_OP_DIVU, 32'd9, 32'd3, 1'b1, 32'd3);
    tag_a_i = 1'b0;
    collect("tag_div", 33, 1'b0);
    chk("tag_set", {31'b0, tag_o}, 32'd1);
    ex_ready_i = 1'b1;
    @(negedge clk);
    ex_ready_i = 1'b0;
    tag_b_i = 1'b1;
    issue(DIV_OP_DIVU, 32'd9, 32'd3, 1'b0, 32'd0);
    tag_b_i = 1'b0;
    repeat (5) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("tag_killed", {31'b0, tag_o}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
